mem_wb_stage: RTL and testbench

Memory/writeback stage of the pipelined ARM core: the consumer of the execute stage's outputs. Registers the E→M control and data bundle, performs loads and stores over a req/ack data-memory handshake, and stalls upstream while an access is outstanding. It also registers the M→W bundle and produces the writeback result, plus the M-stage forwarding value and the W-stage result for the execute-stage operand muxes.

---
 rtl/mem_wb_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback stage: M/W pipeline registers, data-memory req/ack handshake with timeout
module mem_wb_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flushM,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WriteAddrE,
    output logic        stallM,
    output logic        PCSrcM,
    output logic        RegWriteM,
    output logic [31:0] ALUResultM,
    output logic [3:0]  WriteAddrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic        PCSrcW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [3:0]  WriteAddrW,
    output logic [31:0] ResultW
);
    localparam logic [7:0]  TIMEOUT_CNT  = 8'(TIMEOUT);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;

    logic        r_pcsrc_m, r_regwrite_m, r_memtoreg_m, r_memwrite_m;
    logic [31:0] r_alu_m, r_wdata_m;
    logic [3:0]  r_waddr_m;

    logic        r_pcsrc_w, r_regwrite_w, r_memtoreg_w;
    logic [3:0]  r_waddr_w;
    logic [31:0] r_aluout_w, r_rdata_w;
    logic        r_err;

    logic        w_memop, w_complete, w_timeout, w_stall, w_load_done;
    logic [31:0] w_load_data;

    assign w_memop = r_memtoreg_m | r_memwrite_m;

    // r_cnt counts request cycles already spent without an ack
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    if (dmem_ack) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_complete  = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign w_stall     = w_memop & ~w_complete;
    assign w_load_done = w_complete & r_memtoreg_m & ~r_memwrite_m;
    assign w_load_data = w_timeout ? TIMEOUT_DATA : dmem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Flush only clears controls; the data fields are ignored behind a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcsrc_m    <= 1'b0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_alu_m      <= 32'd0;
            r_wdata_m    <= 32'd0;
            r_waddr_m    <= 4'd0;
        end else if (!w_stall) begin
            r_pcsrc_m    <= PCSrcE    & ~flushM;
            r_regwrite_m <= RegWriteE & ~flushM;
            r_memtoreg_m <= MemtoRegE & ~flushM;
            r_memwrite_m <= MemWriteE & ~flushM;
            r_alu_m      <= ALUResultE;
            r_wdata_m    <= WriteDataE;
            r_waddr_m    <= WriteAddrE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pcsrc_w    <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
            r_waddr_w    <= 4'd0;
            r_aluout_w   <= 32'd0;
            r_rdata_w    <= 32'd0;
        end else begin
            if (w_stall) begin
                r_pcsrc_w    <= 1'b0;
                r_regwrite_w <= 1'b0;
                r_memtoreg_w <= 1'b0;
            end else begin
                r_pcsrc_w    <= r_pcsrc_m;
                r_regwrite_w <= r_regwrite_m & ~r_memwrite_m;
                r_memtoreg_w <= r_memtoreg_m & ~r_memwrite_m;
            end
            r_waddr_w  <= r_waddr_m;
            r_aluout_w <= r_alu_m;
            if (w_load_done) begin
                r_rdata_w <= w_load_data;
            end
        end
    end

    assign stallM     = w_stall;
    assign PCSrcM     = r_pcsrc_m;
    assign RegWriteM  = r_regwrite_m;
    assign ALUResultM = r_alu_m;
    assign WriteAddrM = r_waddr_m;
    assign dmem_req   = w_memop | (r_state == S_WAIT);
    assign dmem_we    = r_memwrite_m;
    assign dmem_addr  = r_alu_m;
    assign dmem_wdata = r_wdata_m;
    assign dmem_err   = r_err;
    assign PCSrcW     = r_pcsrc_w;
    assign RegWriteW  = r_regwrite_w;
    assign MemtoRegW  = r_memtoreg_w;
    assign WriteAddrW = r_waddr_w;
    assign ResultW    = r_memtoreg_w ? r_rdata_w : r_aluout_w;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
    localparam int TMO = 4;

    typedef struct packed {
        logic        pc;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa;
    } eop_t;

    typedef struct {
        logic        fl;
        eop_t        e;
        logic        ack;
        logic [31:0] rd;
        logic        x_stall;
        logic        x_req;
        logic        x_we;
        logic        x_rww;
        logic [31:0] x_addr;
        logic [31:0] x_wd;
        logic [31:0] x_res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flushM = 1'b0;
    logic        PCSrcE = 1'b0, RegWriteE = 1'b0, MemtoRegE = 1'b0, MemWriteE = 1'b0;
    logic [31:0] ALUResultE = '0, WriteDataE = '0;
    logic [3:0]  WriteAddrE = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stallM, PCSrcM, RegWriteM, dmem_req, dmem_we, dmem_err;
    logic        PCSrcW, RegWriteW, MemtoRegW;
    logic [31:0] ALUResultM, dmem_addr, dmem_wdata, ResultW;
    logic [3:0]  WriteAddrM, WriteAddrW;

    mem_wb_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(rst_n), .flushM(flushM),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WriteAddrE(WriteAddrE),
        .stallM(stallM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .ALUResultM(ALUResultM), .WriteAddrM(WriteAddrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .WriteAddrW(WriteAddrW), .ResultW(ResultW)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the op sitting in M, how long it has waited, and the retired W view
    eop_t        mo;
    int          waited;
    bit          merr;
    logic        wpc, wrw, wm2r;
    logic [3:0]  wwa;
    logic [31:0] walu, wrd;

    logic        s_stall, s_req, s_we, s_regwm, s_rww;
    logic [31:0] s_addr, s_wd, s_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic eop_t op(input logic pc, input logic rw, input logic m2r, input logic mw,
                                input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
        eop_t o;
        o.pc = pc; o.rw = rw; o.m2r = m2r; o.mw = mw; o.alu = alu; o.wd = wd; o.wa = wa;
        return o;
    endfunction

    task automatic model_reset();
        mo = '0; waited = 0; merr = 0;
        wpc = 0; wrw = 0; wm2r = 0; wwa = '0; walu = '0; wrd = '0;
    endtask

    task automatic drive(input logic fl, input eop_t e, input logic ack, input logic [31:0] rd);
        flushM = fl;
        PCSrcE = e.pc; RegWriteE = e.rw; MemtoRegE = e.m2r; MemWriteE = e.mw;
        ALUResultE = e.alu; WriteDataE = e.wd; WriteAddrE = e.wa;
        dmem_ack = ack; dmem_rdata = rd;
    endtask

    task automatic step(input logic fl, input eop_t e, input logic ack, input logic [31:0] rd);
        bit memop, fired, tmo, stall;
        @(negedge clk);
        drive(fl, e, ack, rd);
        #1;
        s_stall = stallM; s_req = dmem_req; s_we = dmem_we; s_addr = dmem_addr;
        s_wd = dmem_wdata; s_regwm = RegWriteM; s_rww = RegWriteW; s_res = ResultW;
        memop = mo.m2r | mo.mw;
        tmo   = memop && !ack && (waited == TMO);
        fired = memop && (ack || waited == TMO);
        stall = memop && !fired;
        chk("stallM", stallM, stall);
        chk("dmem_req", dmem_req, memop);
        if (memop) begin
            chk("dmem_we", dmem_we, mo.mw);
            chk("dmem_addr", dmem_addr, mo.alu);
        end
        if (mo.mw) chk("dmem_wdata", dmem_wdata, mo.wd);
        chk("PCSrcM", PCSrcM, mo.pc);
        chk("RegWriteM", RegWriteM, mo.rw);
        if (mo.rw || memop) begin
            chk("ALUResultM", ALUResultM, mo.alu);
            chk("WriteAddrM", WriteAddrM, mo.wa);
        end
        chk("PCSrcW", PCSrcW, wpc);
        chk("RegWriteW", RegWriteW, wrw);
        chk("MemtoRegW", MemtoRegW, wm2r);
        if (wrw) begin
            chk("WriteAddrW", WriteAddrW, wwa);
            chk("ResultW", ResultW, wm2r ? wrd : walu);
        end
        chk("dmem_err", dmem_err, merr);
        @(posedge clk);
        if (stall) begin
            wpc = 0; wrw = 0; wm2r = 0;
        end else begin
            wpc  = mo.pc;
            wrw  = mo.rw & ~mo.mw;
            wm2r = mo.m2r & ~mo.mw;
            wwa  = mo.wa;
            walu = mo.alu;
            if (fired && mo.m2r && !mo.mw) wrd = tmo ? 32'hDEADBEEF : rd;
        end
        if (tmo) merr = 1;
        waited = stall ? waited + 1 : 0;
        if (!stall) mo = fl ? '0 : e;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, '0, 0, '0);
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    vec_t tbl[11];
    eop_t NOP, LD40, ST80, ALU1234, e;
    int   cnt;

    initial begin
        NOP     = '0;
        LD40    = op(0, 1, 1, 0, 32'h40, 32'h0, 4'd5);
        ST80    = op(0, 0, 0, 1, 32'h80, 32'hA5A5A5A5, 4'd0);
        ALU1234 = op(0, 1, 0, 0, 32'h1234, 32'h0, 4'd3);
        tbl[0]  = '{0, LD40,    0, 32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        32'h0};
        tbl[1]  = '{0, NOP,     0, 32'h0,        1, 1, 0, 0, 32'h40, 32'h0,        32'h0};
        tbl[2]  = '{0, NOP,     0, 32'h0,        1, 1, 0, 0, 32'h40, 32'h0,        32'h0};
        tbl[3]  = '{0, NOP,     0, 32'h0,        1, 1, 0, 0, 32'h40, 32'h0,        32'h0};
        tbl[4]  = '{0, NOP,     1, 32'hCAFEF00D, 0, 1, 0, 0, 32'h40, 32'h0,        32'h0};
        tbl[5]  = '{0, ST80,    0, 32'h0,        0, 0, 0, 1, 32'h0,  32'h0,        32'hCAFEF00D};
        tbl[6]  = '{0, NOP,     1, 32'h0,        0, 1, 1, 0, 32'h80, 32'hA5A5A5A5, 32'h0};
        tbl[7]  = '{0, NOP,     0, 32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        32'h0};
        tbl[8]  = '{0, ALU1234, 0, 32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        32'h0};
        tbl[9]  = '{0, NOP,     0, 32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        32'h0};
        tbl[10] = '{0, NOP,     0, 32'h0,        0, 0, 0, 1, 32'h0,  32'h0,        32'h1234};

        // Reset with random inputs: every output must read zero
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 1), op($urandom_range(0, 1), 1, 1, $urandom_range(0, 1),
                  $urandom, $urandom, 4'($urandom)), $urandom_range(0, 1), $urandom);
            #1;
            chk("rst_stallM", stallM, 0);     chk("rst_dmem_req", dmem_req, 0);
            chk("rst_dmem_we", dmem_we, 0);   chk("rst_dmem_addr", dmem_addr, 0);
            chk("rst_dmem_wdata", dmem_wdata, 0); chk("rst_dmem_err", dmem_err, 0);
            chk("rst_PCSrcM", PCSrcM, 0);     chk("rst_RegWriteM", RegWriteM, 0);
            chk("rst_ALUResultM", ALUResultM, 0); chk("rst_WriteAddrM", WriteAddrM, 0);
            chk("rst_PCSrcW", PCSrcW, 0);     chk("rst_RegWriteW", RegWriteW, 0);
            chk("rst_MemtoRegW", MemtoRegW, 0); chk("rst_WriteAddrW", WriteAddrW, 0);
            chk("rst_ResultW", ResultW, 0);
        end
        @(negedge clk);
        drive(0, NOP, 0, '0);
        rst_n = 1;

        // Directed table: 3-wait load, zero-wait store, plain ALU op
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].fl, tbl[i].e, tbl[i].ack, tbl[i].rd);
            chk($sformatf("tbl%0d_stall", i), s_stall, tbl[i].x_stall);
            chk($sformatf("tbl%0d_req", i), s_req, tbl[i].x_req);
            chk($sformatf("tbl%0d_rww", i), s_rww, tbl[i].x_rww);
            if (tbl[i].x_req) begin
                chk($sformatf("tbl%0d_we", i), s_we, tbl[i].x_we);
                chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].x_addr);
            end
            if (tbl[i].x_we) chk($sformatf("tbl%0d_wdata", i), s_wd, tbl[i].x_wd);
            if (tbl[i].x_rww) chk($sformatf("tbl%0d_res", i), s_res, tbl[i].x_res);
        end

        // Flush while stalled is ignored; flush while not stalled inserts a bubble
        do_reset();
        step(0, op(0, 1, 1, 0, 32'h44, 0, 4'd2), 0, 0);
        step(1, op(0, 1, 0, 0, 32'h99, 0, 4'd9), 0, 0);
        chk("flush_stall_held", s_stall, 1);
        step(1, op(0, 1, 0, 0, 32'h99, 0, 4'd9), 1, 32'h11223344);
        chk("flush_ld_done", s_stall, 0);
        step(1, op(0, 1, 1, 0, 32'h48, 0, 4'd4), 0, 0);
        chk("flush_bubble_req", s_req, 0);
        chk("flush_bubble_rwm", s_regwm, 0);
        chk("flush_ld_rww", s_rww, 1);
        chk("flush_ld_res", s_res, 32'h11223344);
        step(0, NOP, 0, 0);
        chk("flush_nostall_req", s_req, 0);
        chk("flush_nostall_rwm", s_regwm, 0);

        // Timeout: never acked load stalls TMO cycles and returns DEADBEEF
        do_reset();
        step(0, op(0, 1, 1, 0, 32'h100, 0, 4'd7), 0, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, NOP, 0, 32'h5555AAAA);
            if (s_stall) cnt++;
            if (i == 5) begin
                chk("tmo_rww", s_rww, 1);
                chk("tmo_res", s_res, 32'hDEADBEEF);
            end
        end
        chk("tmo_stall_cycles", cnt, TMO);
        chk("tmo_err", dmem_err, 1);
        step(0, op(0, 1, 1, 0, 32'h104, 0, 4'd8), 0, 0);
        step(0, NOP, 1, 32'h0BADF00D);
        step(0, NOP, 0, 0);
        chk("tmo_good_res", s_res, 32'h0BADF00D);
        chk("tmo_err_sticky", dmem_err, 1);

        // Reset in the middle of a waiting access
        step(0, op(0, 1, 1, 0, 32'h200, 0, 4'd1), 0, 0);
        step(0, NOP, 0, 0);
        step(0, NOP, 0, 0);
        @(negedge clk);
        drive(0, NOP, 0, '0);
        #1;
        chk("mid_req_before", dmem_req, 1);
        rst_n = 0;
        #1;
        chk("mid_req_in_rst", dmem_req, 0);
        chk("mid_stall_in_rst", stallM, 0);
        chk("mid_err_in_rst", dmem_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(0, op(0, 1, 1, 0, 32'h204, 0, 4'd6), 0, 0);
        step(0, NOP, 1, 32'h76543210);
        chk("mid_idle_zero_wait", s_stall, 0);
        step(0, NOP, 0, 0);
        chk("mid_res", s_res, 32'h76543210);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0: e = op(1'($urandom_range(0, 7) == 0), 1'($urandom), 0, 0, $urandom, $urandom, 4'($urandom));
                1: e = op(0, 1'($urandom), 1, 0, $urandom, $urandom, 4'($urandom));
                2: e = op(0, 1'($urandom), 0, 1, $urandom, $urandom, 4'($urandom));
                default: e = op(0, 1'($urandom), 1, 1, $urandom, $urandom, 4'($urandom));
            endcase
            step(1'($urandom_range(0, 19) == 0), e, 1'($urandom_range(0, 99) < 35), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
